priv_1_11_trap_sequencer: RTL and testbench
===========================================

Name: priv_1_11_trap_sequencer

Overview:
Sequences machine-mode trap entry and MRET return for the RV32 privilege unit. Each cycle it picks the highest-priority exception or enabled interrupt and latches cause, EPC and trap value. It then waits for the pipeline to drain and pulses the CSR update strobes, then redirects fetch. It sits between the execute/hazard logic, the CSR file and the pipeline controller, in place of ad-hoc combinational trap logic.

Parameters:
EXC_W, 16, width of exception request vector; bit i = exception cause code i
INT_W, 12, width of interrupt pending/enable vectors; bit i = interrupt cause code i

Ports:
CLK  input  1  core clock
nRST  input  1  synchronous active-low reset
exc_req  input  EXC_W  exception requests from pipeline, level, bit index = cause code
exc_epc  input  32  PC of faulting instruction
exc_tval  input  32  trap value accompanying exc_req
mip  input  INT_W  interrupt pending bits
mie  input  INT_W  interrupt enable bits
mstatus_mie  input  1  current mstatus.MIE
mstatus_mpie  input  1  current mstatus.MPIE
mtvec  input  32  trap vector; [1:0] mode (0 direct, 1 vectored)
mepc  input  32  current mepc, MRET target
int_epc  input  32  PC to save when an interrupt is taken
mret  input  1  MRET in execute
pipe_clear  input  1  pipeline drained, safe to commit
busy  output  1  sequencer not IDLE; pipeline holds fetch
mcause_rup  output  1  mcause write strobe
mepc_rup  output  1  mepc write strobe
mtval_rup  output  1  mtval write strobe
mstatus_rup  output  1  mstatus write strobe
mcause_next  output  32  {intr, 27'b0, code[3:0]}
mepc_next  output  32  saved PC
mtval_next  output  32  saved trap value (0 for interrupts)
mie_next  output  1  new mstatus.MIE
mpie_next  output  1  new mstatus.MPIE
intr  output  1  latched trap is an interrupt
insert_pc  output  1  one-cycle fetch redirect
priv_pc  output  32  redirect target

Behaviour:
- Reset (nRST=0 at CLK edge): state IDLE; every output 0; latched cause/epc/tval cleared.
- States: IDLE, TRAP_WAIT, TRAP_COMMIT, RET_WAIT, RET_COMMIT, REDIRECT.
- Exception priority, cause codes high to low: 3, 12, 1, 2, 0, 8, 9, 11, 6, 4, 15, 13, 7, 5. Any other set bit is ignored.
- Interrupt is eligible when mstatus_mie=1 and (mip & mie) != 0. Interrupt priority high to low: 11, 3, 7, 9, 1, 5, 8, 0, 4.
- IDLE:
  - If any exception is requested: latch code, exc_epc and exc_tval; intr=0; go to TRAP_WAIT.
  - Else if an interrupt is eligible: latch code and int_epc; tval=0; intr=1; go to TRAP_WAIT.
  - Else if mret: go to RET_WAIT.
  - Exceptions beat interrupts, and both beat mret in the same cycle.
- TRAP_WAIT:
  - Hold until pipe_clear=1, then go to TRAP_COMMIT.
  - If the latched trap is an interrupt and an exception arrives, replace the latch with the exception (intr=0) and stay in TRAP_WAIT.
  - All other new events are ignored.
- TRAP_COMMIT (1 cycle):
  - Pulse mcause_rup, mepc_rup, mtval_rup, mstatus_rup.
  - mie_next=0; mpie_next=mstatus_mie.
  - Go to REDIRECT.
- RET_WAIT: hold until pipe_clear, then go to RET_COMMIT. An exception arriving in RET_WAIT aborts the return: latch the exception and go to TRAP_WAIT.
- RET_COMMIT (1 cycle): mstatus_rup=1; mie_next=mstatus_mpie; mpie_next=1; go to REDIRECT.
- REDIRECT (1 cycle): insert_pc=1, then go to IDLE. priv_pc is:
  - after a return: mepc sampled in RET_COMMIT;
  - after a trap: {mtvec[31:2],2'b00}, plus (code<<2) only when intr=1 and mtvec[1:0]=1.
  - Addition is mod 2^32.
- Minimum latency from request to insert_pc is 3 cycles (pipe_clear already high).
- Strobes never assert outside the COMMIT states. busy=1 in every non-IDLE state.
- Reset in any state returns to IDLE next edge with no strobes; a partial commit is never emitted.

Decomposition:
- Shared package machine_mode_types_1_11_pkg gains the state enum trap_seq_state_t, ex_code/int_code priority constants, and the MTVEC_DIRECT/MTVEC_VECTORED constants.
- One combinational sub-module, priv_1_11_cause_prio: exc_req, mip & mie and mstatus_mie in; exc_valid/exc_code and int_valid/int_code out. It is reused for the TRAP_WAIT upgrade check.

Test Plan:
- exc_req bit 2 with exc_epc=0x100, tval=0xDEAD, pipe_clear=1 -> next cycle TRAP_COMMIT, strobes high, mcause_next=0x2, mepc_next=0x100, mtval_next=0xDEAD; following cycle insert_pc=1, priv_pc=mtvec base.
- mtvec=0x8001, mip=mie=bit 7, mstatus_mie=1, int_epc=0x200 -> mcause_next=0x80000007, mtval_next=0, priv_pc=0x801C, mie_next=0, mpie_next=1.
- exc_req bits 2 and 3 together, plus interrupt 11 eligible -> mcause_next=0x3, intr=0.
- Interrupt latched, pipe_clear=0 for 4 cycles, exc_req bit 8 on cycle 2 -> committed mcause_next=0x8, busy held high throughout.
- mret with mepc=0x400, mpie=1, pipe_clear after 2 cycles -> RET_COMMIT mie_next=1, mpie_next=1, only mstatus_rup; then priv_pc=0x400.
- nRST=0 during TRAP_WAIT -> next cycle busy=0, no strobes, no insert_pc.

Source files
------------

// File: rtl/machine_mode_types_1_11_pkg.sv
// Shared machine-mode types: trap sequencer states, cause priority tables, mtvec modes.
package machine_mode_types_1_11_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRAP_WAIT,
    TRAP_COMMIT,
    RET_WAIT,
    RET_COMMIT,
    REDIRECT
  } trap_seq_state_t;

  // Index 0 is the highest priority cause code.
  localparam int N_EXC_PRIO = 14;
  localparam logic [3:0] EXC_PRIO [N_EXC_PRIO] = '{
    4'd3, 4'd12, 4'd1, 4'd2, 4'd0, 4'd8, 4'd9,
    4'd11, 4'd6, 4'd4, 4'd15, 4'd13, 4'd7, 4'd5
  };

  localparam int N_INT_PRIO = 9;
  localparam logic [3:0] INT_PRIO [N_INT_PRIO] = '{
    4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5, 4'd8, 4'd0, 4'd4
  };

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

endpackage

// File: rtl/priv_1_11_cause_prio.sv
// Combinational pick of the highest-priority exception and enabled interrupt.
module priv_1_11_cause_prio
  import machine_mode_types_1_11_pkg::*;
#(
  parameter int EXC_W = 16,
  parameter int INT_W = 12
) (
  input  logic [EXC_W-1:0] exc_req,
  input  logic [INT_W-1:0] int_pend,
  input  logic             mstatus_mie,
  output logic             exc_valid,
  output logic [3:0]       exc_code,
  output logic             int_valid,
  output logic [3:0]       int_code
);

  logic int_any;

  // Walk lowest priority first so the highest-priority hit is written last.
  always_comb begin
    exc_valid = 1'b0;
    exc_code  = 4'd0;
    for (int i = N_EXC_PRIO - 1; i >= 0; i--) begin
      if (int'(EXC_PRIO[i]) < EXC_W && exc_req[EXC_PRIO[i]]) begin
        exc_valid = 1'b1;
        exc_code  = EXC_PRIO[i];
      end
    end
  end

  always_comb begin
    int_any  = 1'b0;
    int_code = 4'd0;
    for (int i = N_INT_PRIO - 1; i >= 0; i--) begin
      if (int'(INT_PRIO[i]) < INT_W && int_pend[INT_PRIO[i]]) begin
        int_any  = 1'b1;
        int_code = INT_PRIO[i];
      end
    end
  end

  assign int_valid = mstatus_mie & int_any;

endmodule

// File: rtl/priv_1_11_trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer: latch, wait for drain, commit CSRs, redirect fetch.
module priv_1_11_trap_sequencer
  import machine_mode_types_1_11_pkg::*;
#(
  parameter int EXC_W = 16,
  parameter int INT_W = 12
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [EXC_W-1:0] exc_req,
  input  logic [31:0]      exc_epc,
  input  logic [31:0]      exc_tval,
  input  logic [INT_W-1:0] mip,
  input  logic [INT_W-1:0] mie,
  input  logic             mstatus_mie,
  input  logic             mstatus_mpie,
  input  logic [31:0]      mtvec,
  input  logic [31:0]      mepc,
  input  logic [31:0]      int_epc,
  input  logic             mret,
  input  logic             pipe_clear,
  output logic             busy,
  output logic             mcause_rup,
  output logic             mepc_rup,
  output logic             mtval_rup,
  output logic             mstatus_rup,
  output logic [31:0]      mcause_next,
  output logic [31:0]      mepc_next,
  output logic [31:0]      mtval_next,
  output logic             mie_next,
  output logic             mpie_next,
  output logic             intr,
  output logic             insert_pc,
  output logic [31:0]      priv_pc
);

  trap_seq_state_t state;
  logic [3:0]  code_q;
  logic [31:0] epc_q, tval_q;
  logic        intr_q;

  logic        exc_valid, int_valid;
  logic [3:0]  exc_code, int_code;
  logic [31:0] trap_target;

  priv_1_11_cause_prio #(.EXC_W(EXC_W), .INT_W(INT_W)) u_prio (
    .exc_req     (exc_req),
    .int_pend    (mip & mie),
    .mstatus_mie (mstatus_mie),
    .exc_valid   (exc_valid),
    .exc_code    (exc_code),
    .int_valid   (int_valid),
    .int_code    (int_code)
  );

  // Only interrupts are vectored; exceptions always land on the base.
  assign trap_target = {mtvec[31:2], 2'b00} +
                       ((intr_q && mtvec[1:0] == MTVEC_VECTORED) ? {26'd0, code_q, 2'b00} : 32'd0);

  assign busy        = (state != IDLE);
  assign mcause_next = {intr_q, 27'd0, code_q};
  assign mepc_next   = epc_q;
  assign mtval_next  = tval_q;
  assign intr        = intr_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= IDLE;
      code_q      <= 4'd0;
      epc_q       <= 32'd0;
      tval_q      <= 32'd0;
      intr_q      <= 1'b0;
      mcause_rup  <= 1'b0;
      mepc_rup    <= 1'b0;
      mtval_rup   <= 1'b0;
      mstatus_rup <= 1'b0;
      mie_next    <= 1'b0;
      mpie_next   <= 1'b0;
      insert_pc   <= 1'b0;
      priv_pc     <= 32'd0;
    end else begin
      // Strobes and redirect are single-cycle; set only on entry to their state.
      mcause_rup  <= 1'b0;
      mepc_rup    <= 1'b0;
      mtval_rup   <= 1'b0;
      mstatus_rup <= 1'b0;
      insert_pc   <= 1'b0;
      case (state)
        IDLE: begin
          if (exc_valid) begin
            code_q <= exc_code;
            epc_q  <= exc_epc;
            tval_q <= exc_tval;
            intr_q <= 1'b0;
            state  <= TRAP_WAIT;
          end else if (int_valid) begin
            code_q <= int_code;
            epc_q  <= int_epc;
            tval_q <= 32'd0;
            intr_q <= 1'b1;
            state  <= TRAP_WAIT;
          end else if (mret) begin
            state <= RET_WAIT;
          end
        end
        TRAP_WAIT: begin
          if (intr_q && exc_valid) begin
            code_q <= exc_code;
            epc_q  <= exc_epc;
            tval_q <= exc_tval;
            intr_q <= 1'b0;
          end else if (pipe_clear) begin
            mcause_rup  <= 1'b1;
            mepc_rup    <= 1'b1;
            mtval_rup   <= 1'b1;
            mstatus_rup <= 1'b1;
            mie_next    <= 1'b0;
            mpie_next   <= mstatus_mie;
            state       <= TRAP_COMMIT;
          end
        end
        TRAP_COMMIT: begin
          insert_pc <= 1'b1;
          priv_pc   <= trap_target;
          state     <= REDIRECT;
        end
        RET_WAIT: begin
          // A late exception wins over the pending return.
          if (exc_valid) begin
            code_q <= exc_code;
            epc_q  <= exc_epc;
            tval_q <= exc_tval;
            intr_q <= 1'b0;
            state  <= TRAP_WAIT;
          end else if (pipe_clear) begin
            mstatus_rup <= 1'b1;
            mie_next    <= mstatus_mpie;
            mpie_next   <= 1'b1;
            state       <= RET_COMMIT;
          end
        end
        RET_COMMIT: begin
          insert_pc <= 1'b1;
          priv_pc   <= mepc;
          state     <= REDIRECT;
        end
        REDIRECT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_priv_1_11_trap_sequencer.sv
// Directed bench for the trap sequencer: cycle-level reference model plus literal spot checks.
module tb_priv_1_11_trap_sequencer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [15:0] exc_req;
  logic [31:0] exc_epc, exc_tval;
  logic [11:0] mip, mie;
  logic        mstatus_mie, mstatus_mpie;
  logic [31:0] mtvec, mepc, int_epc;
  logic        mret, pipe_clear;
  logic        busy, mcause_rup, mepc_rup, mtval_rup, mstatus_rup;
  logic [31:0] mcause_next, mepc_next, mtval_next, priv_pc;
  logic        mie_next, mpie_next, intr, insert_pc;

  int checks = 0;
  int passed = 0;
  bit cmp_en = 0;

  priv_1_11_trap_sequencer #(.EXC_W(16), .INT_W(12)) dut (
    .CLK(CLK), .nRST(nRST), .exc_req(exc_req), .exc_epc(exc_epc), .exc_tval(exc_tval),
    .mip(mip), .mie(mie), .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie),
    .mtvec(mtvec), .mepc(mepc), .int_epc(int_epc), .mret(mret), .pipe_clear(pipe_clear),
    .busy(busy), .mcause_rup(mcause_rup), .mepc_rup(mepc_rup), .mtval_rup(mtval_rup),
    .mstatus_rup(mstatus_rup), .mcause_next(mcause_next), .mepc_next(mepc_next),
    .mtval_next(mtval_next), .mie_next(mie_next), .mpie_next(mpie_next), .intr(intr),
    .insert_pc(insert_pc), .priv_pc(priv_pc)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int exc_pick(input logic [15:0] r);
    int order [14] = '{3, 12, 1, 2, 0, 8, 9, 11, 6, 4, 15, 13, 7, 5};
    foreach (order[k]) if (r[order[k]]) return order[k];
    return -1;
  endfunction

  function automatic int int_pick(input logic [11:0] p, input logic en);
    int order [9] = '{11, 3, 7, 9, 1, 5, 8, 0, 4};
    if (!en) return -1;
    foreach (order[k]) if (p[order[k]]) return order[k];
    return -1;
  endfunction

  int          pend;   // 0 nothing outstanding, 1 trap awaiting drain, 2 return awaiting drain
  bit          do_trap, do_ret, do_jump;
  int          m_code;
  bit          m_intr, m_mie_n, m_mpie_n;
  logic [31:0] m_epc, m_tval, m_pc;

  always @(posedge CLK) begin
    if (!nRST) begin
      pend = 0; do_trap = 0; do_ret = 0; do_jump = 0;
      m_code = 0; m_intr = 0; m_epc = 0; m_tval = 0; m_pc = 0; m_mie_n = 0; m_mpie_n = 0;
    end else begin
      bit was_trap, was_ret, was_jump;
      int ec, ic;
      was_trap = do_trap; was_ret = do_ret; was_jump = do_jump;
      do_trap = 0; do_ret = 0; do_jump = 0;
      ec = exc_pick(exc_req);
      ic = int_pick(mip & mie, mstatus_mie);
      if (was_trap) begin
        do_jump = 1;
        m_pc = {mtvec[31:2], 2'b00} + ((m_intr && mtvec[1:0] == 2'd1) ? 32'(m_code * 4) : 32'd0);
      end else if (was_ret) begin
        do_jump = 1;
        m_pc = mepc;
      end else if (was_jump) begin
        // returning to idle; new events are not seen this cycle
      end else if (pend == 0) begin
        if (ec >= 0) begin pend = 1; m_code = ec; m_intr = 0; m_epc = exc_epc; m_tval = exc_tval; end
        else if (ic >= 0) begin pend = 1; m_code = ic; m_intr = 1; m_epc = int_epc; m_tval = 0; end
        else if (mret) pend = 2;
      end else if (pend == 1) begin
        if (m_intr && ec >= 0) begin m_code = ec; m_intr = 0; m_epc = exc_epc; m_tval = exc_tval; end
        else if (pipe_clear) begin pend = 0; do_trap = 1; m_mie_n = 0; m_mpie_n = mstatus_mie; end
      end else begin
        if (ec >= 0) begin pend = 1; m_code = ec; m_intr = 0; m_epc = exc_epc; m_tval = exc_tval; end
        else if (pipe_clear) begin pend = 0; do_ret = 1; m_mie_n = mstatus_mpie; m_mpie_n = 1; end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("busy", {31'd0, busy}, {31'd0, (pend != 0) || do_trap || do_ret || do_jump});
      chk("cause_strobes", {29'd0, mcause_rup, mepc_rup, mtval_rup},
          {29'd0, do_trap, do_trap, do_trap});
      chk("mstatus_rup", {31'd0, mstatus_rup}, {31'd0, do_trap || do_ret});
      chk("insert_pc", {31'd0, insert_pc}, {31'd0, do_jump});
      if (do_trap || do_ret)
        chk("mstatus_bits", {30'd0, mie_next, mpie_next}, {30'd0, m_mie_n, m_mpie_n});
      if (do_trap) begin
        chk("mcause_next", mcause_next, {m_intr, 27'd0, 4'(m_code)});
        chk("mepc_next", mepc_next, m_epc);
        chk("mtval_next", mtval_next, m_tval);
        chk("intr", {31'd0, intr}, {31'd0, m_intr});
      end
      if (do_jump) chk("priv_pc", priv_pc, m_pc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic quiet();
    exc_req = '0; mip = '0; mie = '0; mret = 0;
  endtask

  task automatic wait_commit(input string name);
    bit seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (mcause_rup || mstatus_rup) begin seen = 1; break; end
      step();
    end
    chk({name, "_commit_seen"}, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    nRST = 0; quiet(); exc_epc = 0; exc_tval = 0; mstatus_mie = 0; mstatus_mpie = 0;
    mtvec = 32'h1000; mepc = 0; int_epc = 0; pipe_clear = 1;
    @(posedge CLK); #1; cmp_en = 1;
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mcause", mcause_next, 32'd0);
    chk("rst_priv_pc", priv_pc, 32'd0);
    nRST = 1;
    step();

    // Exception code 2, direct mtvec.
    exc_req = 16'h0004; exc_epc = 32'h100; exc_tval = 32'hDEAD;
    step(); exc_req = '0;
    wait_commit("exc2");
    chk("exc2_mcause", mcause_next, 32'h2);
    chk("exc2_mepc", mepc_next, 32'h100);
    chk("exc2_mtval", mtval_next, 32'hDEAD);
    step();
    chk("exc2_insert", {31'd0, insert_pc}, 32'd1);
    chk("exc2_pc", priv_pc, 32'h1000);
    step(2);

    // Vectored interrupt 7.
    mtvec = 32'h8001; mip = 12'h080; mie = 12'h080; mstatus_mie = 1; int_epc = 32'h200;
    step(); quiet();
    wait_commit("int7");
    chk("int7_mcause", mcause_next, 32'h80000007);
    chk("int7_mtval", mtval_next, 32'h0);
    chk("int7_mstatus", {30'd0, mie_next, mpie_next}, 32'h1);
    step();
    chk("int7_pc", priv_pc, 32'h801C);
    step(2);

    // Exception 3 beats exception 2 and interrupt 11; exceptions are never vectored.
    exc_req = 16'h000C; exc_epc = 32'h140; exc_tval = 32'h7; mip = 12'h800; mie = 12'h800;
    step(); quiet();
    wait_commit("prio");
    chk("prio_mcause", mcause_next, 32'h3);
    chk("prio_intr", {31'd0, intr}, 32'd0);
    step();
    chk("prio_pc", priv_pc, 32'h8000);
    step(2);

    // Interrupt upgraded by exception 8 while the pipeline drains.
    pipe_clear = 0; mip = 12'h080; mie = 12'h080;
    step(); quiet();
    step();
    chk("upg_busy", {31'd0, busy}, 32'd1);
    exc_req = 16'h0100; exc_epc = 32'h300; exc_tval = 32'h55;
    step(); exc_req = '0;
    step();
    chk("upg_busy2", {31'd0, busy}, 32'd1);
    pipe_clear = 1;
    wait_commit("upg");
    chk("upg_mcause", mcause_next, 32'h8);
    chk("upg_mepc", mepc_next, 32'h300);
    step(3);

    // MRET after a two-cycle drain.
    pipe_clear = 0; mret = 1; mepc = 32'h400; mstatus_mpie = 1; mstatus_mie = 0;
    step(); mret = 0;
    step(2); pipe_clear = 1;
    wait_commit("ret");
    chk("ret_mstatus_rup", {31'd0, mstatus_rup}, 32'd1);
    chk("ret_mcause_rup", {31'd0, mcause_rup}, 32'd0);
    chk("ret_bits", {30'd0, mie_next, mpie_next}, 32'h3);
    step();
    chk("ret_pc", priv_pc, 32'h400);
    step(2);

    // Ignored exception bits, masked interrupt, unimplemented interrupt code 2.
    exc_req = 16'h4400; mip = 12'h004; mie = 12'h004; mstatus_mie = 1;
    step(); quiet(); mip = 12'h800; mie = 12'h800; mstatus_mie = 0;
    step(); quiet();
    chk("ignored_busy", {31'd0, busy}, 32'd0);

    // Vectored target wraps mod 2^32.
    mtvec = 32'hFFFF_FFFD; mip = 12'h800; mie = 12'h800; mstatus_mie = 1;
    step(); quiet();
    wait_commit("wrap");
    step();
    chk("wrap_pc", priv_pc, 32'h28);
    step(2);

    // Reset while a trap waits for drain.
    pipe_clear = 0; exc_req = 16'h0001;
    step(); exc_req = '0;
    step();
    nRST = 0;
    step();
    chk("rst_wait_busy", {31'd0, busy}, 32'd0);
    chk("rst_wait_strobes", {28'd0, mcause_rup, mepc_rup, mtval_rup, mstatus_rup}, 32'd0);
    chk("rst_wait_mepc", mepc_next, 32'd0);
    nRST = 1; pipe_clear = 1;
    step(3);
    chk("rst_wait_insert", {31'd0, insert_pc}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
